spi_frame_ctrl: RTL and testbench
=================================

# spi_frame_ctrl

SPI master-side controller that sequences transactions into the SPI slave of the wrapper. It accepts one command per request handshake, serialises a 10-bit frame `{cmd[1:0], payload[7:0]}` on MOSI under an SS_n window, and for read-data frames captures the 8-bit reply from MISO. It sits between the testbench or system host and the slave/RAM wrapper, owning SS_n framing, inter-frame gaps and read-address/read-data ordering.

## Interface
- `GAP`, default 1: minimum SS_n-high cycles between frames (≥1).
- `RD_LAT`, default 2: cycles between the last MOSI bit and the first MISO sample on read-data frames (≥1).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `req_valid`  in  1  host command valid.
- `req_cmd`  in  2  00 = write-addr, 01 = write-data, 10 = read-addr, 11 = read-data.
- `req_payload`  in  8  frame payload (ignored for read-data; sent as 0).
- `req_ready`  out  1  controller idle and able to accept.
- `SS_n`  out  1  slave select, active-low.
- `MOSI`  out  1  serial data to slave, MSB first.
- `MISO`  in  1  serial data from slave.
- `rd_data`  out  8  last captured read byte.
- `rd_valid`  out  1  one-cycle pulse, `rd_data` updated.
- `done`  out  1  one-cycle pulse when a frame's SS_n window closes.
- `err`  out  1  one-cycle pulse on a rejected command.

## Operation
- States: IDLE, SEL, CMD, SHIFT, HOLD, WAIT, RECV, GAP.
- Reset values: state IDLE, `SS_n`=1, `MOSI`=0, `rd_data`=0, `rd_valid`=0, `done`=0, `err`=0, `addr_pending`=0. `req_ready` = (state==IDLE) & ~`rst`, so it is 0 while `rst` is high.
- Accept: `req_valid` & `req_ready` at a rising edge latches cmd/payload into `frame[9:0]`.
- IDLE -> SEL on accept.
- SEL (1 cycle): `SS_n`=0, `MOSI`=0.
- CMD (1 cycle): `MOSI`=`frame[9]` (slave type-select bit).
- SHIFT (10 cycles): `MOSI`=`frame[9]` down to `frame[0]`, using a 4-bit down-counter.
- After SHIFT:
  - write-addr, write-data, read-addr -> HOLD for 2 cycles, `SS_n`=0, `MOSI`=0.
  - read-data -> WAIT for `RD_LAT` cycles, then RECV for 8 cycles, shifting MISO into a shift register MSB first.
- HOLD/RECV end -> GAP: `SS_n`=1 for `GAP` cycles, then IDLE.
- `done` pulses in the first GAP cycle. `rd_valid` pulses in that same cycle on read-data frames, with `rd_data` updated and held until the next `rd_valid`.
- `addr_pending`: set when a read-addr frame completes; cleared when a read-data frame completes.
- read-data accepted with `addr_pending`=0:
  - frame not sent, `SS_n` stays 1, `err` pulses the next cycle, state stays IDLE.
- read-addr accepted with `addr_pending`=1:
  - sent normally; the address is overwritten and the flag stays set.
- `rst` mid-frame: immediately `SS_n`=1 and all outputs go to their reset values. No `done`/`rd_valid`; the partial frame is dropped.

## Timing
- Edge E = accept edge. Cycle k = the k-th cycle after E.
- Cycle 1 SEL; cycle 2 CMD; cycles 3–12 frame bits 9..0.
- Write and read-addr frames:
  - cycles 13–14 HOLD;
  - `SS_n` low cycles 1–14 (14 cycles);
  - `done` in cycle 15;
  - `req_ready` again in cycle 15+`GAP`.
- Read-data frames:
  - WAIT cycles 13..12+`RD_LAT`;
  - MISO sampled at the end of cycles 13+`RD_LAT`..20+`RD_LAT`;
  - `rd_valid`/`done` in cycle 21+`RD_LAT` (default: cycle 23).
- All outputs are registered; `req_ready` is the only combinational output.
- Back-to-back requests are never overlapped. A request held during a frame is accepted on the first IDLE cycle.

## Configuration
- `SPI_FRAME_CTRL_RD_CHAIN_EN` defined:
  - an accepted read-addr frame is automatically followed, after `GAP`, by a read-data frame without a second request;
  - `req_ready` stays 0 throughout;
  - `done` pulses only after the read-data frame;
  - `rd_valid` is produced as normal.
- Not defined: each frame requires its own request. Read-data ordering is enforced by `addr_pending`/`err`.

## Test plan
- Reset then idle:
  - `SS_n`=1, `MOSI`=0, `rd_data`=0;
  - `req_ready`=0 during `rst` and 1 in the first cycle after release.
- Write-addr, payload 0xA5:
  - MOSI sequence in cycles 2–12 = 0, 0,0,1,0,1,0,0,1,0,1;
  - `SS_n` low exactly 14 cycles; `done` in cycle 15.
- Read-addr 0x3C, then read-data with the slave returning 0x96 (RD_LAT=2):
  - `rd_valid` in cycle 23 of the second frame, `rd_data`=0x96;
  - `addr_pending` cleared.
- Read-data with no prior read-addr:
  - `SS_n` stays 1, `err` pulses once, `req_ready` stays 1.
- Assert `rst` in cycle 7 of a write frame:
  - `SS_n`=1 in the same cycle, no `done`;
  - the next request runs a full, correct frame.
- `SPI_FRAME_CTRL_RD_CHAIN_EN` with read-addr 0x10 and the slave returning 0x5A:
  - two SS_n windows separated by `GAP` cycles;
  - a single `done`, `rd_data`=0x5A.

Source files
------------

// File: rtl/spi_frame_ctrl.sv
// SPI master framer: sends {cmd,payload} under SS_n; read-data frames capture an 8-bit MISO reply.
// Optional SPI_FRAME_CTRL_RD_CHAIN_EN: an accepted read-addr frame is followed automatically by a read-data frame.
module spi_frame_ctrl #(
  parameter int GAP    = 1,
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_cmd,
  input  logic [7:0] req_payload,
  output logic       req_ready,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       err
);
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  localparam int MAXC = (GAP > RD_LAT) ? ((GAP > 8) ? GAP : 8) : ((RD_LAT > 8) ? RD_LAT : 8);
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_CMD, S_SHIFT, S_HOLD, S_WAIT, S_RECV, S_GAP
  } state_t;

  state_t        r_state;
  logic [9:0]    r_frame;
  logic [3:0]    r_bit;
  logic [CW-1:0] r_cnt;
  logic [6:0]    r_shift;
  logic          r_addr_pending;
  logic          r_ss_n;
  logic          r_mosi;
  logic [7:0]    r_rd_data;
  logic          r_rd_valid;
  logic          r_done;
  logic          r_err;
`ifdef SPI_FRAME_CTRL_RD_CHAIN_EN
  logic          r_chain;
`endif
  logic          w_idle;

  assign w_idle    = (r_state == S_IDLE);
  assign req_ready = w_idle & ~rst;
  assign SS_n      = r_ss_n;
  assign MOSI      = r_mosi;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign done      = r_done;
  assign err       = r_err;

  // Outputs are loaded one cycle ahead so each state's drive is already registered on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_frame        <= '0;
      r_bit          <= '0;
      r_cnt          <= '0;
      r_shift        <= '0;
      r_addr_pending <= 1'b0;
      r_ss_n         <= 1'b1;
      r_mosi         <= 1'b0;
      r_rd_data      <= '0;
      r_rd_valid     <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
`ifdef SPI_FRAME_CTRL_RD_CHAIN_EN
      r_chain        <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (req_cmd == CMD_RD_DATA && !r_addr_pending) begin
              r_err <= 1'b1;
            end else begin
              r_frame <= {req_cmd, (req_cmd == CMD_RD_DATA) ? 8'h00 : req_payload};
              r_ss_n  <= 1'b0;
              r_mosi  <= 1'b0;
              r_state <= S_SEL;
            end
          end
        end
        S_SEL: begin
          r_mosi  <= r_frame[9];
          r_state <= S_CMD;
        end
        S_CMD: begin
          r_mosi  <= r_frame[9];
          r_bit   <= 4'd9;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_bit == 4'd0) begin
            r_mosi <= 1'b0;
            if (r_frame[9:8] == CMD_RD_DATA) begin
              r_cnt   <= CW'(RD_LAT - 1);
              r_state <= S_WAIT;
            end else begin
              r_cnt   <= ONE;
              r_state <= S_HOLD;
            end
          end else begin
            r_mosi <= r_frame[r_bit - 4'd1];
            r_bit  <= r_bit - 4'd1;
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_ss_n  <= 1'b1;
            r_cnt   <= CW'(GAP - 1);
            r_state <= S_GAP;
            if (r_frame[9:8] == CMD_RD_ADDR) r_addr_pending <= 1'b1;
`ifdef SPI_FRAME_CTRL_RD_CHAIN_EN
            if (r_frame[9:8] == CMD_RD_ADDR) r_chain <= 1'b1;
            else r_done <= 1'b1;
`else
            r_done <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_cnt   <= CW'(7);
            r_state <= S_RECV;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        S_RECV: begin
          r_shift <= {r_shift[5:0], MISO};
          if (r_cnt == '0) begin
            r_rd_data      <= {r_shift, MISO};
            r_rd_valid     <= 1'b1;
            r_done         <= 1'b1;
            r_addr_pending <= 1'b0;
            r_ss_n         <= 1'b1;
            r_cnt          <= CW'(GAP - 1);
            r_state        <= S_GAP;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        S_GAP: begin
          if (r_cnt == '0) begin
`ifdef SPI_FRAME_CTRL_RD_CHAIN_EN
            if (r_chain) begin
              r_chain <= 1'b0;
              r_frame <= {CMD_RD_DATA, 8'h00};
              r_ss_n  <= 1'b0;
              r_mosi  <= 1'b0;
              r_state <= S_SEL;
            end else begin
              r_state <= S_IDLE;
            end
`else
            r_state <= S_IDLE;
`endif
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Randomized bench for spi_frame_ctrl: per-frame cycle traces compared against a timing-rule reference model.
module tb_spi_frame_ctrl;
  localparam int GAP_C    = 1;
  localparam int RD_LAT_C = 2;
  localparam int W        = 63;
`ifdef SPI_FRAME_CTRL_RD_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_cmd = 2'b00;
  logic [7:0] req_payload = 8'h00;
  logic       req_ready;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic       err;

  int n_chk  = 0;
  int n_pass = 0;

  logic       m_pending = 1'b0;
  logic [7:0] m_rd_data = 8'h00;

  spi_frame_ctrl #(.GAP(GAP_C), .RD_LAT(RD_LAT_C)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_payload(req_payload), .req_ready(req_ready), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Expected per-cycle traces (bit k = k-th cycle after the accept edge), derived from the frame timing rules.
  task automatic model_frame(input logic [1:0] cmd, input logic [7:0] pay, input logic [7:0] mb,
                             input int rst_at,
                             output logic [63:1] e_ss, output logic [63:1] e_mosi,
                             output logic [63:1] e_done, output logic [63:1] e_rdv,
                             output logic [63:1] e_err, output logic [63:1] e_rdy, output int rx);
    logic [9:0] f;
    int len, doneat, o2;
    bit chain;
    e_ss = '1; e_mosi = '0; e_done = '0; e_rdv = '0; e_err = '0; e_rdy = '0; rx = 0;
    if (cmd == 2'b11 && !m_pending) begin
      e_err[1] = 1'b1;
      e_rdy    = '1;
      return;
    end
    chain  = CHAIN && (cmd == 2'b10);
    f      = {cmd, (cmd == 2'b11) ? 8'h00 : pay};
    len    = (cmd == 2'b11) ? 20 + RD_LAT_C : 14;
    doneat = len + 1;
    if (cmd == 2'b11) rx = 13 + RD_LAT_C;
    for (int k = 1; k <= W; k++) begin
      if (k <= len) e_ss[k] = 1'b0;
      if (k == 2) e_mosi[k] = f[9];
      if (k >= 3 && k <= 12) e_mosi[k] = f[12 - k];
    end
    if (chain) begin
      o2     = 14 + GAP_C;
      rx     = o2 + 13 + RD_LAT_C;
      doneat = o2 + 21 + RD_LAT_C;
      for (int k = o2 + 1; k <= o2 + 20 + RD_LAT_C; k++) e_ss[k] = 1'b0;
      e_mosi[o2 + 2] = 1'b1;
      e_mosi[o2 + 3] = 1'b1;
      e_mosi[o2 + 4] = 1'b1;
    end
    e_done[doneat] = 1'b1;
    if (cmd == 2'b11 || chain) e_rdv[doneat] = 1'b1;
    for (int k = doneat + GAP_C; k <= W; k++) e_rdy[k] = 1'b1;
    if (cmd == 2'b11 || chain) begin
      m_rd_data = mb;
      m_pending = 1'b0;
    end else if (cmd == 2'b10) begin
      m_pending = 1'b1;
    end
    if (rst_at > 0) begin
      for (int k = rst_at; k <= W; k++) begin
        e_ss[k] = 1'b1; e_mosi[k] = 1'b0; e_done[k] = 1'b0; e_rdv[k] = 1'b0;
        e_rdy[k] = (k >= rst_at + 2);
      end
      m_pending = 1'b0;
      m_rd_data = 8'h00;
      rx = 0;
    end
  endtask

  task automatic run_frame(input logic [1:0] cmd, input logic [7:0] pay, input logic [7:0] mb,
                           input int rst_at);
    logic [63:1] e_ss, e_mosi, e_done, e_rdv, e_err, e_rdy;
    logic [63:1] o_ss, o_mosi, o_done, o_rdv, o_err, o_rdy;
    int rx, t;
    model_frame(cmd, pay, mb, rst_at, e_ss, e_mosi, e_done, e_rdv, e_err, e_rdy, rx);
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("rdy_wait", {63'd0, req_ready}, 64'd1);
    req_valid   = 1'b1;
    req_cmd     = cmd;
    req_payload = pay;
    @(posedge clk);
    o_ss = '0; o_mosi = '0; o_done = '0; o_rdv = '0; o_err = '0; o_rdy = '0;
    for (int k = 1; k <= W; k++) begin
      if (k == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ss", {63'd0, SS_n}, 64'd1);
        chk("rst_mid_rdy", {63'd0, req_ready}, 64'd0);
      end
      @(negedge clk);
      o_ss[k] = SS_n; o_mosi[k] = MOSI; o_done[k] = done;
      o_rdv[k] = rd_valid; o_err[k] = err; o_rdy[k] = req_ready;
      if (k == 1) req_valid = 1'b0;
      if (rst_at > 0 && k == rst_at + 1) rst = 1'b0;
      if (rx > 0 && k >= rx && k <= rx + 7) MISO = mb[7 - (k - rx)];
      else MISO = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    chk("ss_n_trace",  {1'b0, o_ss},   {1'b0, e_ss});
    chk("mosi_trace",  {1'b0, o_mosi}, {1'b0, e_mosi});
    chk("done_trace",  {1'b0, o_done}, {1'b0, e_done});
    chk("rdv_trace",   {1'b0, o_rdv},  {1'b0, e_rdv});
    chk("err_trace",   {1'b0, o_err},  {1'b0, e_err});
    chk("ready_trace", {1'b0, o_rdy},  {1'b0, e_rdy});
    chk("rd_data",     {56'd0, rd_data}, {56'd0, m_rd_data});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ss_n",    {63'd0, SS_n}, 64'd1);
    chk("rst_mosi",    {63'd0, MOSI}, 64'd0);
    chk("rst_rd_data", {56'd0, rd_data}, 64'd0);
    chk("rst_rdy",     {63'd0, req_ready}, 64'd0);
    chk("rst_pulses",  {61'd0, done, rd_valid, err}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", {63'd0, req_ready}, 64'd1);

    run_frame(2'b00, 8'hA5, 8'h00, 0);
    run_frame(2'b10, 8'h3C, 8'h00, 0);
    run_frame(2'b11, 8'h77, 8'h96, 0);
    run_frame(2'b11, 8'h00, 8'h33, 0);
    run_frame(2'b01, 8'h5E, 8'h00, 7);
    run_frame(2'b01, 8'hC3, 8'h00, 0);
    run_frame(2'b10, 8'h10, 8'h5A, 0);
    for (int i = 0; i < 30; i++) begin
      run_frame(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
